// File: rtl/shape_display_pkg.sv
// Shared definitions for the shape selection display controller.
//   - state_t        : controller states (IDLE, SHOW, ERR)
//   - C_*            : shape codes, 1..9, 0 = no shape
//   - SEG_*          : active-low gfedcba glyphs
//   - GL_*           : glyph select codes fed to seg7_decoder (0..9 = digits)
//   - digit_to_seg   : decimal digit -> active-low segments
//   - is_onehot      : exactly one shape line set
//   - onehot_to_code : shape line index + 1
package shape_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_ERR
    } state_t;

    localparam logic [3:0] C_NONE       = 4'd0;
    localparam logic [3:0] C_CIRCULO    = 4'd1;
    localparam logic [3:0] C_CUADRADO   = 4'd2;
    localparam logic [3:0] C_TRIANGULO  = 4'd3;
    localparam logic [3:0] C_OVALO      = 4'd4;
    localparam logic [3:0] C_RECTANGULO = 4'd5;
    localparam logic [3:0] C_ROMBO      = 4'd6;
    localparam logic [3:0] C_HEXAGONO   = 4'd7;
    localparam logic [3:0] C_PENTAGONO  = 4'd8;
    localparam logic [3:0] C_ESTRELLA   = 4'd9;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [4:0] GL_DASH  = 5'd10;
    localparam logic [4:0] GL_E     = 5'd11;
    localparam logic [4:0] GL_R     = 5'd12;
    localparam logic [4:0] GL_F     = 5'd13;
    localparam logic [4:0] GL_BLANK = 5'd14;

    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic is_onehot(input logic [8:0] f);
        return (f != 9'd0) && ((f & (f - 9'd1)) == 9'd0);
    endfunction

    // Only meaningful when is_onehot(f); otherwise the lowest set bit wins.
    function automatic logic [3:0] onehot_to_code(input logic [8:0] f);
        logic [3:0] c;
        c = C_NONE;
        for (int i = 8; i >= 0; i--) begin
            if (f[i]) c = 4'(i + 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational glyph decoder.
//   sel : glyph select, 0..9 decimal digits, GL_* for symbols
//   seg : active-low segments gfedcba
module seg7_decoder
    import shape_display_pkg::*;
(
    input  logic [4:0] sel,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (sel < 5'd10) begin
            seg = digit_to_seg(sel[3:0]);
        end else begin
            case (sel)
                GL_DASH: seg = SEG_DASH;
                GL_E:    seg = SEG_E;
                GL_R:    seg = SEG_R;
                GL_F:    seg = SEG_F;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/shape_display_ctrl.sv
// Receiving end of the image-selector interface. On a rising edge of Enter
// the one-hot shape lines are validated; a valid shape is latched and shown
// as "F  n" on a 4-digit multiplexed display, an invalid one shows "Err "
// for ERR_CYCLES clocks.
//   Clk          : system clock, rising edge
//   Reset        : synchronous, active-high
//   Figuras[8:0] : one-hot shape lines
//   Enter        : confirm level, rising edge used
//   Codigo       : latched shape code 1..9, 0 = none
//   CodigoValido : Codigo holds a confirmed shape
//   Error        : controller is in ERR
//   Anodos       : active-low digit enables, [3] leftmost
//   Segmentos    : active-low gfedcba
module shape_display_ctrl
    import shape_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int ERR_CYCLES  = 50000000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [8:0] Figuras,
    input  logic       Enter,
    output logic [3:0] Codigo,
    output logic       CodigoValido,
    output logic       Error,
    output logic [3:0] Anodos,
    output logic [6:0] Segmentos
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int TW = $clog2(ERR_CYCLES);
    localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] TMAX = TW'(ERR_CYCLES - 1);

    state_t        state_q, state_n;
    logic [3:0]    codigo_q, codigo_n;
    logic          valid_q, valid_n;
    logic [TW-1:0] timer_q, timer_n;
    logic          error_q;
    logic          enter_d;
    logic [RW-1:0] rcnt_q, rcnt_n;
    logic [1:0]    idx_q, idx_n;
    logic [3:0]    anodos_q;
    logic [6:0]    seg_q, seg_n;
    logic [4:0]    glyph;
    logic          edge_det, sel_ok;
    logic [3:0]    sel_code;

    assign edge_det = Enter & ~enter_d;
    assign sel_ok   = is_onehot(Figuras);
    assign sel_code = onehot_to_code(Figuras);

    always_comb begin
        state_n  = state_q;
        codigo_n = codigo_q;
        valid_n  = valid_q;
        timer_n  = timer_q;
        // An edge always wins over the ERR timeout.
        if (edge_det && sel_ok) begin
            state_n  = ST_SHOW;
            codigo_n = sel_code;
            valid_n  = 1'b1;
        end else if (edge_det) begin
            state_n = ST_ERR;
            timer_n = '0;
        end else if (state_q == ST_ERR) begin
            if (timer_q == TMAX) begin
                state_n = valid_q ? ST_SHOW : ST_IDLE;
            end else begin
                timer_n = timer_q + 1'b1;
            end
        end
    end

    always_comb begin
        rcnt_n = rcnt_q + 1'b1;
        idx_n  = idx_q;
        if (rcnt_q == RMAX) begin
            rcnt_n = '0;
            idx_n  = idx_q + 2'd1;
        end
    end

    // Glyph is chosen from the next-cycle state so that Segmentos, Anodos and
    // Codigo all change together, one clock after the sampled edge.
    always_comb begin
        glyph = GL_BLANK;
        case (state_n)
            ST_IDLE: glyph = GL_DASH;
            ST_SHOW: begin
                if (idx_n == 2'd3)      glyph = GL_F;
                else if (idx_n == 2'd0) glyph = {1'b0, codigo_n};
                else                    glyph = GL_BLANK;
            end
            ST_ERR: begin
                if (idx_n == 2'd3)      glyph = GL_E;
                else if (idx_n == 2'd0) glyph = GL_BLANK;
                else                    glyph = GL_R;
            end
            default: glyph = GL_BLANK;
        endcase
    end

    seg7_decoder u_dec (
        .sel(glyph),
        .seg(seg_n)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            codigo_q <= C_NONE;
            valid_q  <= 1'b0;
            timer_q  <= '0;
            error_q  <= 1'b0;
            enter_d  <= 1'b1;
            rcnt_q   <= '0;
            idx_q    <= 2'd0;
            anodos_q <= 4'b1110;
            seg_q    <= SEG_DASH;
        end else begin
            state_q  <= state_n;
            codigo_q <= codigo_n;
            valid_q  <= valid_n;
            timer_q  <= timer_n;
            error_q  <= (state_n == ST_ERR);
            enter_d  <= Enter;
            rcnt_q   <= rcnt_n;
            idx_q    <= idx_n;
            anodos_q <= ~(4'b0001 << idx_n);
            seg_q    <= seg_n;
        end
    end

    assign Codigo       = codigo_q;
    assign CodigoValido = valid_q;
    assign Error        = error_q;
    assign Anodos       = anodos_q;
    assign Segmentos    = seg_q;

endmodule

// File: tb/tb_shape_display_ctrl.sv
// Self-checking bench for shape_display_ctrl with REFRESH_DIV=4, ERR_CYCLES=20.
// A cycle model predicts the outputs each clock and queues them; each
// scenario pops and compares, plus targeted checks against fixed values.
module tb_shape_display_ctrl;

    localparam int RDIV = 4;
    localparam int ERRC = 20;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [8:0] Figuras = 9'h000;
    logic       Enter = 1'b0;
    logic [3:0] Codigo;
    logic       CodigoValido;
    logic       Error;
    logic [3:0] Anodos;
    logic [6:0] Segmentos;

    shape_display_ctrl #(.REFRESH_DIV(RDIV), .ERR_CYCLES(ERRC)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Figuras(Figuras),
        .Enter(Enter),
        .Codigo(Codigo),
        .CodigoValido(CodigoValido),
        .Error(Error),
        .Anodos(Anodos),
        .Segmentos(Segmentos)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] code;
        logic       valid;
        logic       err;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t sbq[$];
    exp_t ex;
    wire [16:0] obs = {Codigo, CodigoValido, Error, Anodos, Segmentos};

    int errors = 0;
    int checks = 0;

    // Model state: 0 idle, 1 show, 2 err
    int   m_st = 0, m_code = 0, m_timer = 0, m_cnt = 0, m_idx = 0;
    logic m_valid = 1'b0, m_ed = 1'b1;

    function automatic logic [6:0] exp_seg(input int st, input int code, input int idx);
        logic [6:0] s;
        s = 7'b1111111;
        if (st == 0) s = 7'b0111111;
        else if (st == 2) begin
            if (idx == 3) s = 7'b0000110;
            else if (idx == 0) s = 7'b1111111;
            else s = 7'b0101111;
        end else begin
            if (idx == 3) s = 7'b0001110;
            else if (idx == 0) begin
                case (code)
                    1: s = 7'b1111001; 2: s = 7'b0100100; 3: s = 7'b0110000;
                    4: s = 7'b0011001; 5: s = 7'b0010010; 6: s = 7'b0000010;
                    7: s = 7'b1111000; 8: s = 7'b0000000; 9: s = 7'b0010000;
                    default: s = 7'b1111111;
                endcase
            end
        end
        return s;
    endfunction

    // Drive one clock of stimulus, advance the model, queue the expectation.
    task automatic cyc(input logic [8:0] f, input logic e, input logic r);
        exp_t nx;
        int   hot, cd;
        logic edg;
        Figuras = f;
        Enter   = e;
        Reset   = r;
        @(posedge Clk);
        if (r) begin
            m_st = 0; m_code = 0; m_valid = 1'b0; m_timer = 0;
            m_ed = 1'b1; m_cnt = 0; m_idx = 0;
        end else begin
            edg  = e && !m_ed;
            m_ed = e;
            hot = 0; cd = 0;
            for (int i = 0; i < 9; i++) if (f[i]) begin hot++; cd = i + 1; end
            if (edg && hot == 1) begin
                m_st = 1; m_code = cd; m_valid = 1'b1;
            end else if (edg) begin
                m_st = 2; m_timer = 0;
            end else if (m_st == 2) begin
                if (m_timer == ERRC - 1) m_st = m_valid ? 1 : 0;
                else m_timer++;
            end
            if (m_cnt == RDIV - 1) begin m_cnt = 0; m_idx = (m_idx + 1) % 4; end
            else m_cnt++;
        end
        #1;
        nx.code  = 4'(m_code);
        nx.valid = m_valid;
        nx.err   = (m_st == 2);
        nx.an    = ~(4'b0001 << m_idx);
        nx.seg   = exp_seg(m_st, m_code, m_idx);
        sbq.push_back(nx);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(9'h000, 1'b0, 1'b1);
            ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin errors++; $display("FAIL reset_sb k=%0d got=%h exp=%h", k, obs, ex); end
        end
        checks++;
        if ({Codigo, CodigoValido, Error} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=000000", {Codigo, CodigoValido, Error});
        end
        checks++;
        if ({Anodos, Segmentos} !== {4'b1110, 7'b0111111}) begin
            errors++; $display("FAIL reset_disp got=%b exp=%b", {Anodos, Segmentos}, {4'b1110, 7'b0111111});
        end
    endtask

    task automatic test_idle_scan();
        logic [3:0] an_exp;
        for (int k = 1; k <= 40; k++) begin
            cyc(9'h000, 1'b0, 1'b0);
            ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin errors++; $display("FAIL idle_sb k=%0d got=%h exp=%h", k, obs, ex); end
            an_exp = ~(4'b0001 << ((k / 4) % 4));
            checks++;
            if (Anodos !== an_exp) begin errors++; $display("FAIL idle_anodos k=%0d got=%b exp=%b", k, Anodos, an_exp); end
            checks++;
            if (Segmentos !== 7'b0111111) begin errors++; $display("FAIL idle_seg k=%0d got=%b exp=0111111", k, Segmentos); end
        end
    endtask

    task automatic test_show();
        cyc(9'h004, 1'b0, 1'b0);
        ex = sbq.pop_front(); checks++;
        if (obs !== ex) begin errors++; $display("FAIL show_pre got=%h exp=%h", obs, ex); end
        cyc(9'h004, 1'b1, 1'b0);
        ex = sbq.pop_front(); checks++;
        if (obs !== ex) begin errors++; $display("FAIL show_edge_sb got=%h exp=%h", obs, ex); end
        checks++;
        if ({Codigo, CodigoValido} !== {4'd3, 1'b1}) begin
            errors++; $display("FAIL show_code got=%0d/%b exp=3/1", Codigo, CodigoValido);
        end
        for (int k = 0; k < 16; k++) begin
            cyc(9'h004, 1'b0, 1'b0);
            ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin errors++; $display("FAIL show_sb k=%0d got=%h exp=%h", k, obs, ex); end
            if (Anodos === 4'b1110) begin
                checks++;
                if (Segmentos !== 7'b0110000) begin errors++; $display("FAIL show_digit0 got=%b exp=0110000", Segmentos); end
            end
            if (Anodos === 4'b0111) begin
                checks++;
                if (Segmentos !== 7'b0001110) begin errors++; $display("FAIL show_digit3 got=%b exp=0001110", Segmentos); end
            end
        end
    endtask

    task automatic test_err_from_show();
        int ecnt;
        ecnt = 0;
        for (int k = 0; k < 30; k++) begin
            cyc(9'h000, (k == 0), 1'b0);
            ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin errors++; $display("FAIL errshow_sb k=%0d got=%h exp=%h", k, obs, ex); end
            if (Error === 1'b1) ecnt++;
        end
        checks++;
        if (ecnt != ERRC) begin errors++; $display("FAIL errshow_len got=%0d exp=%0d", ecnt, ERRC); end
        checks++;
        if ({Codigo, CodigoValido, Error} !== {4'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL errshow_keep got=%0d/%b/%b exp=3/1/0", Codigo, CodigoValido, Error);
        end
    endtask

    task automatic test_err_from_idle();
        int ecnt;
        cyc(9'h000, 1'b0, 1'b1);
        ex = sbq.pop_front();
        ecnt = 0;
        for (int k = 0; k < 26; k++) begin
            cyc(9'h011, (k == 1), 1'b0);
            ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin errors++; $display("FAIL erridle_sb k=%0d got=%h exp=%h", k, obs, ex); end
            if (Error === 1'b1) ecnt++;
        end
        checks++;
        if (ecnt != ERRC) begin errors++; $display("FAIL erridle_len got=%0d exp=%0d", ecnt, ERRC); end
        checks++;
        if ({Codigo, CodigoValido, Segmentos} !== {4'd0, 1'b0, 7'b0111111}) begin
            errors++; $display("FAIL erridle_back got=%0d/%b/%b exp=0/0/0111111", Codigo, CodigoValido, Segmentos);
        end
        for (int k = 0; k < 6; k++) begin
            cyc(9'h011, (k == 0), 1'b0);
            ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin errors++; $display("FAIL erridle_re k=%0d got=%h exp=%h", k, obs, ex); end
        end
        cyc(9'h100, 1'b1, 1'b0);
        ex = sbq.pop_front(); checks++;
        if (obs !== ex) begin errors++; $display("FAIL err_valid_sb got=%h exp=%h", obs, ex); end
        checks++;
        if ({Codigo, CodigoValido, Error} !== {4'd9, 1'b1, 1'b0}) begin
            errors++; $display("FAIL err_valid_exit got=%0d/%b/%b exp=9/1/0", Codigo, CodigoValido, Error);
        end
    endtask

    task automatic test_err_restart();
        int ecnt;
        // enter ERR, restart at timer 10, count the full hold after restart
        for (int k = 0; k < 12; k++) begin
            cyc(9'h000, (k == 1), 1'b0);
            ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin errors++; $display("FAIL restart_sb k=%0d got=%h exp=%h", k, obs, ex); end
        end
        ecnt = 0;
        for (int k = 0; k < 25; k++) begin
            cyc(9'h000, (k == 0), 1'b0);
            ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin errors++; $display("FAIL restart2_sb k=%0d got=%h exp=%h", k, obs, ex); end
            if (Error === 1'b1) ecnt++;
        end
        checks++;
        if (ecnt != ERRC) begin errors++; $display("FAIL restart_len got=%0d exp=%0d", ecnt, ERRC); end
        // invalid edge coinciding with the timeout keeps ERR
        for (int k = 0; k < 21; k++) begin
            cyc(9'h003, (k == 0 || k == 20), 1'b0);
            ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin errors++; $display("FAIL coincide_sb k=%0d got=%h exp=%h", k, obs, ex); end
        end
        checks++;
        if ({Error, Codigo} !== {1'b1, 4'd9}) begin
            errors++; $display("FAIL coincide_err got=%b/%0d exp=1/9", Error, Codigo);
        end
        for (int k = 0; k < 22; k++) begin
            cyc(9'h003, 1'b0, 1'b0);
            ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin errors++; $display("FAIL coincide2_sb k=%0d got=%h exp=%h", k, obs, ex); end
        end
    endtask

    task automatic test_held_enter();
        cyc(9'h001, 1'b0, 1'b0);
        ex = sbq.pop_front();
        for (int k = 0; k < 10; k++) begin
            cyc((k < 2) ? 9'h001 : 9'h002, 1'b1, 1'b0);
            ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin errors++; $display("FAIL held_sb k=%0d got=%h exp=%h", k, obs, ex); end
            checks++;
            if (Codigo !== 4'd1) begin errors++; $display("FAIL held_code k=%0d got=%0d exp=1", k, Codigo); end
        end
        cyc(9'h002, 1'b1, 1'b1);
        ex = sbq.pop_front(); checks++;
        if (obs !== ex) begin errors++; $display("FAIL held_rst_sb got=%h exp=%h", obs, ex); end
        for (int k = 0; k < 6; k++) begin
            cyc(9'h002, 1'b1, 1'b0);
            ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin errors++; $display("FAIL held_after_sb k=%0d got=%h exp=%h", k, obs, ex); end
            checks++;
            if ({Codigo, CodigoValido} !== 5'b0) begin
                errors++; $display("FAIL held_after_code k=%0d got=%0d/%b exp=0/0", k, Codigo, CodigoValido);
            end
        end
    endtask

    task automatic test_reset_mid_err();
        for (int k = 0; k < 12; k++) begin
            cyc(9'h000, (k == 1), 1'b0);
            ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin errors++; $display("FAIL miderr_sb k=%0d got=%h exp=%h", k, obs, ex); end
        end
        checks++;
        if (Error !== 1'b1) begin errors++; $display("FAIL miderr_pre got=%b exp=1", Error); end
        cyc(9'h000, 1'b0, 1'b1);
        ex = sbq.pop_front(); checks++;
        if (obs !== ex) begin errors++; $display("FAIL miderr_rst_sb got=%h exp=%h", obs, ex); end
        checks++;
        if ({Error, Anodos, Codigo, Segmentos} !== {1'b0, 4'b1110, 4'd0, 7'b0111111}) begin
            errors++; $display("FAIL miderr_rst got=%b exp=%b", {Error, Anodos, Codigo, Segmentos},
                               {1'b0, 4'b1110, 4'd0, 7'b0111111});
        end
        for (int k = 0; k < 25; k++) begin
            cyc(9'h000, 1'b0, 1'b0);
            ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin errors++; $display("FAIL miderr_after k=%0d got=%h exp=%h", k, obs, ex); end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] f;
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 3))
                0: f = 9'h000;
                1: f = 9'h003 << $urandom_range(0, 7);
                default: f = 9'h001 << $urandom_range(0, 8);
            endcase
            cyc(f, k[0], 1'b0);
            ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin errors++; $display("FAIL b2b_sb k=%0d got=%h exp=%h", k, obs, ex); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_show();
        test_err_from_show();
        test_err_from_idle();
        test_err_restart();
        test_held_enter();
        test_reset_mid_err();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
